multi_rate_capture: RTL and testbench



---
 rtl/multi_rate_pkg.sv | 17 +
 rtl/multi_rate_capture_channel.sv | 103 ++++++++++
 rtl/multi_rate_capture.sv | 57 +++++
 tb/tb_multi_rate_capture.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_rate_pkg.sv
// rtl/multi_rate_pkg.sv - shared constants and per-channel ratio record for multi_rate_capture
package multi_rate_pkg;

    localparam int CHANNELS_DEF = 4;
    localparam int DIV_W_DEF    = 8;
    localparam int DIV_INIT_DEF = 1;

    // Storage width for divide values; every DIV_W up to this fits zero-extended.
    localparam int DIV_W_MAX    = 32;

    // A divide value together with its "waiting to be applied" flag.
    typedef struct packed {
        logic [DIV_W_MAX-1:0] div;
        logic                 pend_v;
    } ch_cfg_t;

endpackage

// File: rtl/multi_rate_capture_channel.sv
// rtl/multi_rate_capture_channel.sv - one rate channel: counter, ratio shadow, tick, phase, capture
module rate_channel
    import multi_rate_pkg::*;
#(
    parameter int DATA_W   = 1,
    parameter int DIV_W    = DIV_W_DEF,
    parameter int DIV_INIT = DIV_INIT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable_i,
    input  logic              sync_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              wr_i,
    input  logic [DIV_W-1:0]  div_i,
    output logic              tick_o,
    output logic              phase_o,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic              ack_o
);

    logic [DIV_W-1:0]     cnt_q, cnt_d;
    logic [DIV_W_MAX-1:0] div_act_q, div_act_d;
    ch_cfg_t              pend_q, pend_d;
    logic                 tick_q, tick_d;
    logic                 phase_q, phase_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ack_q, ack_d;
    logic                 terminal;

    // cnt only ever runs up to div_act, so an equality compare is enough.
    assign terminal = (DIV_W_MAX'(cnt_q) == div_act_q);

    // Next-state: sync realign beats the terminal edge; a pending ratio is
    // swapped in only at a period boundary so no period is cut short.
    always_comb begin
        cnt_d     = cnt_q;
        div_act_d = div_act_q;
        pend_d    = pend_q;
        tick_d    = 1'b0;
        phase_d   = phase_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ack_d     = 1'b0;
        if (sync_i || terminal) begin
            cnt_d = '0;
            if (sync_i) begin
                phase_d = 1'b0;
            end else begin
                tick_d  = 1'b1;
                phase_d = ~phase_q;
                if (enable_i) begin
                    data_d  = data_i;
                    valid_d = 1'b1;
                end
            end
            if (pend_q.pend_v) begin
                div_act_d     = pend_q.div;
                pend_d.pend_v = 1'b0;
                ack_d         = 1'b1;
            end
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end
        // A write on a boundary edge lands after the swap, so it waits a period.
        if (wr_i) begin
            pend_d.div    = DIV_W_MAX'(div_i);
            pend_d.pend_v = 1'b1;
        end
    end

    // Channel state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            div_act_q <= DIV_W_MAX'(DIV_INIT);
            pend_q    <= '0;
            tick_q    <= 1'b0;
            phase_q   <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            div_act_q <= div_act_d;
            pend_q    <= pend_d;
            tick_q    <= tick_d;
            phase_q   <= phase_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ack_q     <= ack_d;
        end
    end

    assign tick_o  = tick_q;
    assign phase_o = phase_q;
    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign ack_o   = ack_q;

endmodule

// File: rtl/multi_rate_capture.sv
// rtl/multi_rate_capture.sv - multi-channel clock-enable rate divider with data capture
module multi_rate_capture
    import multi_rate_pkg::*;
#(
    parameter  int CHANNELS = CHANNELS_DEF,
    parameter  int DATA_W   = 1,
    parameter  int DIV_W    = DIV_W_DEF,
    parameter  int DIV_INIT = DIV_INIT_DEF,
    localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic [DATA_W-1:0]          data_i,
    input  logic                       sync,
    input  logic                       cfg_wr,
    input  logic [CH_W-1:0]            cfg_ch,
    input  logic [DIV_W-1:0]           cfg_div,
    output logic [CHANNELS-1:0]        cfg_ack,
    output logic [CHANNELS-1:0]        tick_o,
    output logic [CHANNELS-1:0]        phase_o,
    output logic [CHANNELS*DATA_W-1:0] data_o,
    output logic [CHANNELS-1:0]        valid_o
);

    logic [CHANNELS-1:0] wr_sel;

    // Decode the config strobe; channel numbers past the last channel are dropped.
    always_comb begin
        wr_sel = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            wr_sel[c] = cfg_wr && (int'(cfg_ch) == c) && (int'(cfg_ch) < CHANNELS);
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        rate_channel #(
            .DATA_W   (DATA_W),
            .DIV_W    (DIV_W),
            .DIV_INIT (DIV_INIT)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .enable_i (enable),
            .sync_i   (sync),
            .data_i   (data_i),
            .wr_i     (wr_sel[c]),
            .div_i    (cfg_div),
            .tick_o   (tick_o[c]),
            .phase_o  (phase_o[c]),
            .data_o   (data_o[c*DATA_W +: DATA_W]),
            .valid_o  (valid_o[c]),
            .ack_o    (cfg_ack[c])
        );
    end

endmodule

// File: tb/tb_multi_rate_capture.sv
// tb/tb_multi_rate_capture.sv - self-checking bench for multi_rate_capture against an edge-schedule model
module tb_multi_rate_capture;

    localparam int N     = 4;
    localparam int DW    = 4;
    localparam int DIVW  = 8;
    localparam int DINIT = 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            enable;
    logic [DW-1:0]   data_i;
    logic            sync;
    logic            cfg_wr;
    logic [1:0]      cfg_ch;
    logic [DIVW-1:0] cfg_div;
    logic [N-1:0]    cfg_ack, tick_o, phase_o, valid_o;
    logic [N*DW-1:0] data_o;
    logic [2:0]      ack3, tick3, phase3, valid3;
    logic [3*DW-1:0] data3;

    multi_rate_capture #(.CHANNELS(N), .DATA_W(DW), .DIV_W(DIVW), .DIV_INIT(DINIT)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .data_i(data_i), .sync(sync),
        .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_ack(cfg_ack),
        .tick_o(tick_o), .phase_o(phase_o), .data_o(data_o), .valid_o(valid_o)
    );

    // Three-channel copy: channel number 3 is out of range here and must be ignored.
    multi_rate_capture #(.CHANNELS(3), .DATA_W(DW), .DIV_W(DIVW), .DIV_INIT(DINIT)) dut3 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .data_i(data_i), .sync(sync),
        .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_ack(ack3),
        .tick_o(tick3), .phase_o(phase3), .data_o(data3), .valid_o(valid3)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: each channel keeps the absolute edge number of its next tick,
    // its active ratio R and an optional pending ratio.
    int              e = 0;
    int              cur_edge = -1;
    int              nt[N], ract[N], rpend[N];
    bit              pv[N];
    bit              model_live = 0;
    logic [N-1:0]    x_tick, x_phase, x_valid, x_ack;
    logic [N*DW-1:0] x_data;

    always @(posedge clk) begin
        if (!rst_n) begin
            e = 0;
            cur_edge = -1;
            for (int c = 0; c < N; c++) begin
                nt[c] = DINIT; ract[c] = DINIT + 1; rpend[c] = 0; pv[c] = 0;
            end
            x_tick = '0; x_phase = '0; x_valid = '0; x_ack = '0; x_data = '0;
        end else begin
            cur_edge = e;
            for (int c = 0; c < N; c++) begin
                x_tick[c] = 1'b0; x_valid[c] = 1'b0; x_ack[c] = 1'b0;
                if (sync || e == nt[c]) begin
                    if (sync) begin
                        x_phase[c] = 1'b0;
                    end else begin
                        x_tick[c]  = 1'b1;
                        x_phase[c] = ~x_phase[c];
                        x_valid[c] = enable;
                        if (enable) x_data[c*DW +: DW] = data_i;
                    end
                    x_ack[c] = pv[c];
                    if (pv[c]) ract[c] = rpend[c];
                    pv[c] = 0;
                    nt[c] = e + ract[c];
                end
                if (cfg_wr && int'(cfg_ch) == c) begin
                    rpend[c] = int'(cfg_div) + 1;
                    pv[c] = 1;
                end
            end
            e++;
        end
        model_live = 1;
    end

    // Event log used by the hand-computed expectations.
    int tq[N][$];
    int aq[N][$];
    int val_cnt = 0;

    task automatic clear_mon();
        for (int c = 0; c < N; c++) begin
            tq[c].delete();
            aq[c].delete();
        end
        val_cnt = 0;
    endtask

    function automatic int tq_at(input int c, input int i);
        return (tq[c].size() > i) ? tq[c][i] : -1;
    endfunction

    function automatic int aq_at(input int c, input int i);
        return (aq[c].size() > i) ? aq[c][i] : -1;
    endfunction

    // Per-cycle compare against the model, shortly after each active edge.
    always begin
        @(posedge clk);
        #2;
        if (model_live) begin
            chk("tick", tick_o, x_tick);
            chk("phase", phase_o, x_phase);
            chk("valid", valid_o, x_valid);
            chk("ack", cfg_ack, x_ack);
            chk("data", data_o, x_data);
            chk("tick3", tick3, x_tick[2:0]);
            chk("phase3", phase3, x_phase[2:0]);
            chk("valid3", valid3, x_valid[2:0]);
            chk("ack3", ack3, x_ack[2:0]);
            chk("data3", data3, x_data[3*DW-1:0]);
            for (int c = 0; c < N; c++) begin
                if (tick_o[c]) tq[c].push_back(cur_edge);
                if (cfg_ack[c]) aq[c].push_back(cur_edge);
                if (valid_o[c]) val_cnt++;
            end
        end
    end

    task automatic write(input int ch, input int div);
        cfg_wr  = 1'b1;
        cfg_ch  = 2'(ch);
        cfg_div = DIVW'(div);
        @(negedge clk);
        cfg_wr  = 1'b0;
    endtask

    task automatic wait_tick(input int c, output int k);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tick_o[c] && n < 600);
        checks++;
        if (n >= 600) begin
            errors++;
            $display("FAIL wait_tick ch%0d: no tick within 600 cycles, required one", c);
        end
        k = cur_edge;
    endtask

    // Data bit 0 toggles every cycle, upper bits random.
    initial begin
        data_i = '0;
        forever begin
            @(negedge clk);
            data_i = data_i ^ DW'($urandom | 1);
        end
    end

    int k, m;
    logic [N*DW-1:0] snap;

    initial begin
        rst_n = 1'b0; enable = 1'b1; sync = 1'b0;
        cfg_wr = 1'b0; cfg_ch = '0; cfg_div = '0;
        repeat (3) @(negedge clk);
        chk("reset_tick", tick_o, 0);
        chk("reset_data", data_o, 0);
        rst_n = 1'b1;
        clear_mon();
        repeat (8) @(negedge clk);
        chk("dflt_ticks", tq[0].size(), 4);
        chk("dflt_first", tq_at(0, 0), 1);
        chk("dflt_ch3_2nd", tq_at(3, 1), 3);
        chk("dflt_phase", phase_o, 0);

        // ch2: div=0 mid-period, then div=4 while ticking every edge.
        wait_tick(2, k);
        clear_mon();
        write(2, 0);
        repeat (6) @(negedge clk);
        chk("ch2_ack1_n", aq[2].size(), 1);
        chk("ch2_ack1_e", aq_at(2, 0), k + 2);
        chk("ch2_per1", tq_at(2, 2) - tq_at(2, 1), 1);
        chk("ch0_per2", tq_at(0, 1) - tq_at(0, 0), 2);
        m = cur_edge + 1;
        clear_mon();
        write(2, 4);
        repeat (14) @(negedge clk);
        chk("ch2_ack2_n", aq[2].size(), 1);
        chk("ch2_ack2_e", aq_at(2, 0), m + 1);
        chk("ch2_per5a", tq_at(2, 2), m + 6);
        chk("ch2_per5b", tq_at(2, 3), m + 11);

        // ch1: first write on a terminal edge, second overrides it before the next.
        wait_tick(1, k);
        @(negedge clk);
        clear_mon();
        write(1, 3);
        write(1, 6);
        repeat (18) @(negedge clk);
        chk("ch1_ack_n", aq[1].size(), 1);
        chk("ch1_ack_e", aq_at(1, 0), k + 4);
        chk("ch1_per7a", tq_at(1, 2), k + 11);
        chk("ch1_per7b", tq_at(1, 3), k + 18);

        // ch0: pending div=2, then div=5 written on the terminal edge.
        wait_tick(0, k);
        clear_mon();
        write(0, 2);
        write(0, 5);
        repeat (12) @(negedge clk);
        chk("ch0_t0", tq_at(0, 0), k + 2);
        chk("ch0_t1", tq_at(0, 1), k + 5);
        chk("ch0_t2", tq_at(0, 2), k + 11);
        chk("ch0_ack_n", aq[0].size(), 2);
        chk("ch0_ack0", aq_at(0, 0), k + 2);
        chk("ch0_ack1", aq_at(0, 1), k + 5);

        // ch3: div=4, then sync at cnt=2 with pending div=1.
        write(3, 4);
        repeat (12) @(negedge clk);
        wait_tick(3, k);
        write(3, 1);
        @(negedge clk);
        sync = 1'b1;
        @(negedge clk);
        sync = 1'b0;
        chk("sync_edge", cur_edge, k + 3);
        chk("sync_phase", phase_o, 0);
        chk("sync_tick", tick_o, 0);
        chk("sync_ack3", cfg_ack[3], 1);
        clear_mon();
        repeat (3) @(negedge clk);
        chk("sync_ch3_next", tq_at(3, 0), k + 5);

        // Capture disabled: ticks continue, nothing captured.
        snap = data_o;
        clear_mon();
        enable = 1'b0;
        repeat (20) @(negedge clk);
        chk("dis_valid", val_cnt, 0);
        chk("dis_hold", data_o, snap);
        chk("dis_ticks", tq[2].size() >= 3, 1);
        enable = 1'b1;

        // Mid-period reset clears everything on that edge.
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_tick", tick_o, 0);
        chk("rst_phase", phase_o, 0);
        chk("rst_valid", valid_o, 0);
        chk("rst_ack", cfg_ack, 0);
        chk("rst_data", data_o, 0);
        rst_n = 1'b1;

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            enable  = ($urandom % 8) != 0;
            sync    = ($urandom % 97) == 0;
            cfg_wr  = ($urandom % 6) == 0;
            cfg_ch  = 2'($urandom % 4);
            cfg_div = (($urandom % 8) == 0) ? DIVW'($urandom) : DIVW'($urandom % 10);
            rst_n   = ($urandom % 1500) != 0;
            @(negedge clk);
        end
        sync = 1'b0; cfg_wr = 1'b0; rst_n = 1'b1;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
